// File: rtl/kyber_ntt.sv
// rtl/kyber_ntt.sv - Kyber forward NTT (q = 3329, n = 256) over 32 words of 8 x 16-bit lanes
//
// Optional feature macro: KYBER_NTT_INPUT_REDUCE_EN
//   defined   : each 16-bit input lane is reduced mod Q on load
//   undefined : only lane bits [11:0] are stored (inputs must already be < Q)
//
// Cycle timing, counted in rising edges from the edge E that accepts input word 31:
//   E+1 .. E+896   one butterfly written per edge (7 layers x 128)
//   E+896 -> E+897 one fixed FSM transition cycle (OUTPUT entered, first word registered)
//   E+897 .. E+928 valid_out registered high, words 0..31
//   E+929          done registered high for one cycle
//   Last accepted word to done = 896 + 32 + 1 = 929 edges, the transition included.
module kyber_ntt (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         valid_in,
  input  logic [127:0] data_in,
  output logic         ready_in,
  output logic [127:0] data_out,
  output logic         valid_out,
  output logic         done
);

  localparam logic [11:0] Q         = 12'd3329;
  localparam int          N         = 256;
  localparam int          WORDS     = 32;
  // floor(2^26 / Q); the quotient estimate is never above the true quotient and at most one below
  localparam logic [14:0] BARRETT_M = 15'd20158;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_OUTPUT  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Exact reduction of any value below 2^24 into [0, Q)
  function automatic logic [11:0] mod_q(input logic [23:0] p);
    logic [38:0] prod;
    logic [12:0] q_est;
    logic [23:0] r;
    prod  = {15'd0, p} * {24'd0, BARRETT_M};
    q_est = 13'(prod >> 26);
    r     = p - {11'd0, q_est} * {12'd0, Q};
    if (r >= {12'd0, Q}) r = r - {12'd0, Q};
    return 12'(r);
  endfunction

  // Bring a value in [0, 2Q) into [0, Q)
  function automatic logic [11:0] cond_sub(input logic [12:0] v);
    return (v >= {1'b0, Q}) ? 12'(v - {1'b0, Q}) : 12'(v);
  endfunction

  // 17^bitrev7(idx) mod Q, evaluated at elaboration only
  function automatic logic [11:0] zeta_calc(input int idx);
    int e;
    int r;
    e = 0;
    for (int b = 0; b < 7; b++)
      if (idx[b]) e = e | (1 << (6 - b));
    r = 1;
    for (int i = 0; i < e; i++) r = (r * 17) % 3329;
    return 12'(r);
  endfunction

  logic [11:0] zeta_rom [128];
  for (genvar gi = 0; gi < 128; gi++) begin : g_zeta
    localparam logic [11:0] ZV = zeta_calc(gi);
    assign zeta_rom[gi] = ZV;
  end

  logic [2:0]   state;
  logic [4:0]   w_cnt;
  logic [2:0]   layer;
  logic [6:0]   bf;
  logic [4:0]   out_cnt;
  logic [11:0]  coef [N];

  logic [7:0]   len;
  logic [7:0]   bf_ext;
  logic [7:0]   j_idx;
  logic [7:0]   jl_idx;
  logic [6:0]   k_idx;
  logic [11:0]  a_lo;
  logic [11:0]  a_hi;
  logic [11:0]  zeta;
  logic [11:0]  t_val;
  logic [11:0]  new_lo;
  logic [11:0]  new_hi;
  logic [11:0]  load_lane [8];
  logic [127:0] out_word;

  assign ready_in = (state == S_LOAD);

  // Butterfly addressing: bf enumerates the 128 butterflies of a layer in reference order
  always_comb begin
    len    = 8'd128 >> layer;
    bf_ext = {1'b0, bf};
    j_idx  = (bf_ext & (len - 8'd1)) | ((bf_ext & ~(len - 8'd1)) << 1);
    jl_idx = j_idx + len;
    k_idx  = (7'd1 << layer) + (bf >> (3'd7 - layer));
    a_lo   = coef[j_idx];
    a_hi   = coef[jl_idx];
    zeta   = zeta_rom[k_idx];
    t_val  = mod_q({12'd0, zeta} * {12'd0, a_hi});
    new_lo = cond_sub({1'b0, a_lo} + {1'b0, t_val});
    new_hi = cond_sub({1'b0, a_lo} + {1'b0, Q} - {1'b0, t_val});
  end

`ifdef KYBER_NTT_INPUT_REDUCE_EN
  // Full reduction so any 16-bit lane value is accepted
  always_comb begin
    for (int l = 0; l < 8; l++) load_lane[l] = mod_q({8'd0, data_in[16*l +: 16]});
  end
`else
  logic [7:0] unused_lane_hi;
  // Lanes are already below Q; only the low 12 bits are kept
  always_comb begin
    for (int l = 0; l < 8; l++) begin
      load_lane[l]      = data_in[16*l +: 12];
      unused_lane_hi[l] = |data_in[16*l+12 +: 4];
    end
  end
`endif

  // Gather the eight coefficients of the word being emitted
  always_comb begin
    out_word = '0;
    for (int l = 0; l < 8; l++) out_word[16*l +: 16] = {4'd0, coef[{out_cnt, 3'(l)}]};
  end

  // Coefficient storage: eight lanes per accepted word, two coefficients per butterfly
  always_ff @(posedge clk) begin
    if (!reset && state == S_LOAD && valid_in) begin
      coef[{w_cnt, 3'd0}] <= load_lane[0];
      coef[{w_cnt, 3'd1}] <= load_lane[1];
      coef[{w_cnt, 3'd2}] <= load_lane[2];
      coef[{w_cnt, 3'd3}] <= load_lane[3];
      coef[{w_cnt, 3'd4}] <= load_lane[4];
      coef[{w_cnt, 3'd5}] <= load_lane[5];
      coef[{w_cnt, 3'd6}] <= load_lane[6];
      coef[{w_cnt, 3'd7}] <= load_lane[7];
    end else if (!reset && state == S_COMPUTE) begin
      coef[j_idx]  <= new_lo;
      coef[jl_idx] <= new_hi;
    end
  end

  // Sequencer: load, 7 x 128 butterflies, 32 output words, one done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      w_cnt     <= '0;
      layer     <= '0;
      bf        <= '0;
      out_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            w_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (valid_in) begin
            w_cnt <= w_cnt + 5'd1;
            if (w_cnt == 5'(WORDS - 1)) begin
              state <= S_COMPUTE;
              layer <= '0;
              bf    <= '0;
            end
          end
        end
        S_COMPUTE: begin
          bf <= bf + 7'd1;
          if (bf == 7'd127) begin
            if (layer == 3'd6) begin
              state   <= S_OUTPUT;
              out_cnt <= '0;
            end else begin
              layer <= layer + 3'd1;
            end
          end
        end
        S_OUTPUT: begin
          valid_out <= 1'b1;
          data_out  <= out_word;
          out_cnt   <= out_cnt + 5'd1;
          if (out_cnt == 5'd31) state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_ntt.sv
// tb/tb_kyber_ntt.sv - directed self-checking bench for kyber_ntt
module tb_kyber_ntt;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         valid_in;
  logic [127:0] data_in;
  logic         ready_in;
  logic [127:0] data_out;
  logic         valid_out;
  logic         done;

  always #5 clk = ~clk;

  kyber_ntt dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .done      (done)
  );

  int           checks = 0;
  int           passed = 0;
  int           in_poly   [256];
  int           exp_poly  [256];
  logic [127:0] exp_words [32];
  logic [127:0] got_words [32];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // 17^bitrev7(k) mod 3329 by square-and-multiply
  function automatic int zeta_ref(input int k);
    int e = 0;
    int r = 1;
    int base = 17;
    for (int b = 0; b < 7; b++) e = e * 2 + ((k >> b) & 1);
    while (e > 0) begin
      if ((e & 1) != 0) r = (r * base) % 3329;
      base = (base * base) % 3329;
      e = e >> 1;
    end
    return r;
  endfunction

  // Textbook forward NTT on exp_poly
  task automatic ref_ntt();
    int k = 1;
    int t;
    int z;
    for (int i = 0; i < 256; i++) exp_poly[i] = in_poly[i];
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        z = zeta_ref(k);
        k++;
        for (int j = s; j < s + len; j++) begin
          t = (z * exp_poly[j + len]) % 3329;
          exp_poly[j + len] = (exp_poly[j] - t + 3329) % 3329;
          exp_poly[j]       = (exp_poly[j] + t) % 3329;
        end
      end
    end
    for (int w = 0; w < 32; w++)
      for (int l = 0; l < 8; l++) exp_words[w][16*l +: 16] = 16'(exp_poly[8*w + l]);
  endtask

  function automatic logic [127:0] pack_in(input int w);
    logic [127:0] v = '0;
    for (int l = 0; l < 8; l++) v[16*l +: 16] = 16'(in_poly[8*w + l]);
    return v;
  endfunction

  task automatic load_poly(input string name, input bit gaps);
    int w = 0;
    int n = 0;
    int ready_lows = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_ready_up"}, 128'(ready_in), 128'd1);
    while (w < 32 && n < 200) begin
      valid_in = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_in  = valid_in ? pack_in(w) : {4{32'hdeadbeef}};
      if (!ready_in) ready_lows++;
      @(negedge clk);
      n++;
      if (valid_in) w++;
    end
    valid_in = 1'b0;
    data_in  = '0;
    check({name, "_words_accepted"}, 128'(w), 128'd32);
    check({name, "_ready_held"}, 128'(ready_lows), 128'd0);
    check({name, "_ready_drop"}, 128'(ready_in), 128'd0);
  endtask

  task automatic finish_ntt(input string name);
    int n = 0;
    int ready_highs = 0;
    int out_gaps = 0;
    int done_during = 0;
    while (!valid_out && n < 2000) begin
      start    = (n == 100);
      valid_in = (n < 40);
      data_in  = '1;
      if (ready_in || done) ready_highs++;
      @(negedge clk);
      n++;
    end
    start    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    check({name, "_first_valid_latency"}, 128'(n), 128'd897);
    check({name, "_idle_during_compute"}, 128'(ready_highs), 128'd0);
    for (int i = 0; i < 32; i++) begin
      if (!valid_out) out_gaps++;
      if (done) done_during++;
      got_words[i] = data_out;
      @(negedge clk);
    end
    check({name, "_valid_contiguous"}, 128'(out_gaps), 128'd0);
    check({name, "_done_overlap"}, 128'(done_during), 128'd0);
    check({name, "_done_pulse"}, 128'(done), 128'd1);
    check({name, "_valid_after"}, 128'(valid_out), 128'd0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 128'(done), 128'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_w%0d", name, i), got_words[i], exp_words[i]);
  endtask

  task automatic set_delta(input int idx);
    for (int i = 0; i < 256; i++) in_poly[i] = 0;
    in_poly[idx] = 1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready_in", 128'(ready_in), 128'd0);
    check("reset_valid_out", 128'(valid_out), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_data_out", data_out, 128'd0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) in_poly[i] = 0;
    for (int w = 0; w < 32; w++) exp_words[w] = 128'd0;
    load_poly("zero", 1'b0);
    finish_ntt("zero");

    set_delta(0);
    for (int w = 0; w < 32; w++) exp_words[w] = 128'h00000001000000010000000100000001;
    load_poly("delta0", 1'b0);
    finish_ntt("delta0");

    set_delta(1);
    for (int w = 0; w < 32; w++) exp_words[w] = 128'h00010000000100000001000000010000;
    load_poly("delta1", 1'b0);
    finish_ntt("delta1");

    for (int i = 0; i < 256; i++) in_poly[i] = $urandom_range(0, 3328);
    ref_ntt();
    load_poly("rand", 1'b0);
    finish_ntt("rand");
    load_poly("rand_gaps", 1'b1);
    finish_ntt("rand_gaps");

    for (int i = 0; i < 256; i++) in_poly[i] = 3328;
    ref_ntt();
    load_poly("max", 1'b1);
    finish_ntt("max");

    for (int i = 0; i < 256; i++) in_poly[i] = $urandom_range(0, 3328);
    load_poly("midreset", 1'b0);
    for (int c = 0; c < 300; c++) begin
      start = (c == 150);
      @(negedge clk);
    end
    start = 1'b0;
    check("midreset_start_ignored", 128'(ready_in), 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ready_in", 128'(ready_in), 128'd0);
    check("midreset_valid_out", 128'(valid_out), 128'd0);
    check("midreset_done", 128'(done), 128'd0);
    check("midreset_data_out", data_out, 128'd0);
    reset = 1'b0;

    set_delta(0);
    for (int w = 0; w < 32; w++) exp_words[w] = 128'h00000001000000010000000100000001;
    load_poly("after_reset", 1'b0);
    finish_ntt("after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
